// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings, response record and master FSM state type.
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Width of one queued response: write + err + rdata.
  localparam int unsigned RSP_W = 34;

  typedef enum logic {
    ST_RUN,
    ST_ERR2
  } state_e;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/ahb2_rsp_fifo.sv
// Synchronous FIFO holding completed responses until the consumer takes them.
// Push is ignored when full and pop is ignored when empty.
module ahb2_rsp_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               pop_data_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push    = push_i & (count_q != CW'(DEPTH));
  assign do_pop     = pop_i & (count_q != '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping with wrap for non-power-of-two depths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb2_req_master.sv
// Single-transfer AHB2 initiator: valid/ready requests in, pipelined NONSEQ
// word transfers out, in-order responses back.
// Optional feature macro: AHB2_MST_RSP_FIFO_EN adds rsp_ready and a
// RSP_DEPTH-entry response FIFO with request back-pressure.
module ahb2_req_master
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
`ifdef AHB2_MST_RSP_FIFO_EN
  input  logic                  rsp_ready,
`endif
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  state_e state_q, state_d;

  // Address-phase stage (A) and data-phase stage (D).
  logic                  a_valid_q, a_write_q;
  logic [ADDR_WIDTH-1:0] a_addr_q;
  logic [31:0]           a_wdata_q;
  logic                  d_valid_q, d_write_q;
  logic [31:0]           d_wdata_q;

  logic        advance, cancel, retire, retire_err;
  logic [31:0] retire_rdata;
  logic        req_fire, rsp_credit;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a two-cycle ERROR response parks us in ST_ERR2 for its second cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (d_valid_q && (hresp == HRESP_ERROR) && !hready) state_d = ST_ERR2;
      ST_ERR2: if (hready) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: pipeline advance, retirement and cancellation of the pending address phase.
  always_comb begin
    advance    = 1'b0;
    cancel     = 1'b0;
    retire     = 1'b0;
    retire_err = 1'b0;
    htrans     = HTRANS_IDLE;
    case (state_q)
      ST_RUN: begin
        advance    = hready;
        retire     = hready & d_valid_q;
        retire_err = (hresp == HRESP_ERROR);
        cancel     = d_valid_q & (hresp == HRESP_ERROR) & !hready;
      end
      ST_ERR2: begin
        retire     = hready & d_valid_q;
        retire_err = 1'b1;
        cancel     = 1'b1;
      end
      default: ;
    endcase
    if (a_valid_q && !cancel) htrans = HTRANS_NONSEQ;
    retire_rdata = (d_write_q || retire_err) ? '0 : hrdata;
  end

  assign haddr  = a_addr_q;
  assign hwrite = a_write_q;
  assign hwdata = d_wdata_q;
  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;

  assign req_ready = rst_n & (!a_valid_q | advance) & rsp_credit;
  assign req_fire  = req_valid & req_ready;

  // Pipeline stages. In ST_ERR2, D retires without A moving, so A is re-issued afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_addr_q  <= '0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
    end else begin
      if (advance) begin
        d_valid_q <= a_valid_q;
        if (a_valid_q) begin
          d_write_q <= a_write_q;
          d_wdata_q <= a_wdata_q;
        end
      end else if (retire) begin
        d_valid_q <= 1'b0;
      end
      if (req_fire) begin
        a_valid_q <= 1'b1;
        a_write_q <= req_write;
        a_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        a_wdata_q <= req_wdata;
      end else if (advance) begin
        a_valid_q <= 1'b0;
      end
    end
  end

`ifdef AHB2_MST_RSP_FIFO_EN
  rsp_t                           push_rsp, head_rsp;
  logic                           fifo_empty;
  logic [$clog2(RSP_DEPTH+1)-1:0] fifo_count;

  assign push_rsp = '{write: d_write_q, err: retire_err, rdata: retire_rdata};

  // Everything already in flight is counted so the FIFO can never overflow.
  assign rsp_credit = (32'(fifo_count) + 32'(a_valid_q) + 32'(d_valid_q)) < RSP_DEPTH;

  ahb2_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (retire),
    .push_data_i (push_rsp),
    .pop_i       (rsp_valid & rsp_ready),
    .pop_data_o  (head_rsp),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_write = head_rsp.write;
  assign rsp_err   = head_rsp.err;
  assign rsp_rdata = head_rsp.rdata;
`else
  localparam int unsigned unused_rsp_depth = RSP_DEPTH;

  logic        rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  assign rsp_credit = 1'b1;

  // Registered one-cycle response pulse from the retiring data phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= retire;
      if (retire) begin
        rsp_write_q <= d_write_q;
        rsp_err_q   <= retire_err;
        rsp_rdata_q <= retire_rdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
`endif

endmodule
